apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  - APB requester that drives the pclk-domain APB slave.
//  - Accepts one command at a time on a valid/ready command port.
//  - Sequences APB SETUP->ACCESS phases, waits for pready, returns prdata/pslverr on a valid/ready response port.
//  - Single outstanding transfer; no pipelining across transfers.
// PARAMETERS
//  ADDR_W        32   paddr / cmd_addr width
//  DATA_W        32   pwdata / prdata width; pstrb width = DATA_W/8
//  TIMEOUT_CYC   256  max ACCESS cycles before abort (used only with APB_MASTER_TIMEOUT_EN)
// PORTS
//  pclk        in   1         sole clock, rising edge
//  preset      in   1         synchronous, active-high reset
//  cmd_valid   in   1         command present
//  cmd_ready   out  1         command accepted when cmd_valid & cmd_ready
//  cmd_addr    in   ADDR_W    target address
//  cmd_write   in   1         1 = write, 0 = read
//  cmd_wdata   in   DATA_W    write data
//  cmd_strb    in   DATA_W/8  write byte strobes
//  cmd_prot    in   3         protection attributes
//  rsp_valid   out  1         response present
//  rsp_ready   in   1         response consumed when rsp_valid & rsp_ready
//  rsp_rdata   out  DATA_W    read data (0 for writes)
//  rsp_err     out  1         pslverr, or timeout abort
//  paddr       out  ADDR_W    APB address
//  pprot       out  3         APB protection
//  pselx       out  1         APB select
//  penable     out  1         APB enable
//  pwrite      out  1         APB direction
//  pwdata      out  DATA_W    APB write data
//  pstrb       out  DATA_W/8  APB strobes
//  pready      in   1         slave ready
//  prdata      in   DATA_W    slave read data
//  pslverr     in   1         slave error
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0 except cmd_ready = 1. Applies at next edge, also mid-transfer.
//    In-flight transfer and pending response are discarded.
//  - FSM states:
//    - IDLE: cmd_ready = 1. On cmd accept, register addr/write/wdata/strb/prot -> SETUP.
//    - SETUP: pselx = 1, penable = 0; exactly one cycle -> ACCESS.
//    - ACCESS: pselx = 1, penable = 1. Hold until pready = 1; on that edge capture prdata
//      (reads only, else 0) and pslverr -> RESP.
//    - RESP: pselx = penable = 0; rsp_valid = 1, payload stable until rsp_ready -> IDLE.
//  - cmd_ready is 0 outside IDLE. Minimum 4 cycles per transfer (accept, SETUP, ACCESS, RESP).
//  - paddr, pprot, pwrite, pwdata, pstrb:
//    - come from registers loaded at accept; constant through SETUP and ACCESS;
//    - hold last value in IDLE/RESP.
//  - Reads drive pstrb = 0 regardless of cmd_strb.
//  - rsp_ready asserted outside RESP is ignored. cmd_valid while busy is not accepted.
//  - pready/pslverr/prdata are sampled only in ACCESS; ignored elsewhere.
// CONFIGURATION
//  - APB_MASTER_TIMEOUT_EN defined: a wait counter clears on entering ACCESS and counts ACCESS cycles.
//    - If pready is still 0 after TIMEOUT_CYC cycles: drop pselx/penable -> RESP with
//      rsp_err = 1, rsp_rdata = 0.
//    - pready arriving in the same cycle as the limit wins (normal completion).
//  - Undefined: no counter; ACCESS waits indefinitely.
// STRUCTURE
//  - apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), PROT_* constants, ADDR_W/DATA_W defaults.
//  - Sub-module apb_master_cmd_reg: command capture register loaded on accept.
//  - FSM and response register stay in apb_master.
// TESTING
//  - Write, pready tied 1: addr 0x10, wdata 0xDEADBEEF, strb 0xF -> SETUP 1 cycle, ACCESS 1 cycle,
//    rsp_valid with rsp_err = 0; pwdata stable both phases.
//  - Read, pready after 3 wait cycles, prdata 0x12345678 -> penable high 4 cycles;
//    rsp_rdata 0x12345678; pstrb = 0 throughout.
//  - Write with pslverr = 1 at pready, rsp_ready held 0 for 5 cycles ->
//    rsp_valid/rsp_err = 1 held stable; cmd_ready = 0 until response taken.
//  - preset asserted during ACCESS -> next edge pselx = penable = rsp_valid = 0, cmd_ready = 1;
//    no response ever issued.
//  - APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 4, pready held 0 -> abort after 4 ACCESS cycles:
//    rsp_err = 1, rsp_rdata = 0.
//  - Back-to-back: cmd_valid held with 2 queued commands, rsp_ready = 1 ->
//    second accept exactly 1 cycle after first RESP; no APB phase overlap.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM state encoding,
// APB protection bits and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    localparam logic [2:0] PROT_NORMAL = 3'b000;
    localparam logic [2:0] PROT_PRIV   = 3'b001;
    localparam logic [2:0] PROT_NONSEC = 3'b010;
    localparam logic [2:0] PROT_INSTR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_master_cmd_reg.sv
// Command capture register: latches the accepted command and presents it
// unchanged on the APB address/control/data lines until the next accept.
module apb_master_cmd_reg
    import apb_pkg::*;
#(
    parameter  int unsigned ADDR_W = APB_ADDR_W,
    parameter  int unsigned DATA_W = APB_DATA_W,
    localparam int unsigned STRB_W = strb_w(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              write_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] strb_i,
    input  logic [2:0]        prot_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              write_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] strb_o,
    output logic [2:0]        prot_o
);

    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic [2:0]        prot_q;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
        end else if (load_i) begin
            addr_q  <= addr_i;
            write_q <= write_i;
            wdata_q <= wdata_i;
            // Reads never present byte strobes on the bus.
            strb_q  <= write_i ? strb_i : '0;
            prot_q  <= prot_i;
        end
    end

    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign wdata_o = wdata_q;
    assign strb_o  = strb_q;
    assign prot_o  = prot_q;

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP -> ACCESS -> response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait cycles.
module apb_master
    import apb_pkg::*;
#(
    parameter  int unsigned ADDR_W      = APB_ADDR_W,
    parameter  int unsigned DATA_W      = APB_DATA_W,
    parameter  int unsigned TIMEOUT_CYC = 256,
    localparam int unsigned STRB_W      = strb_w(DATA_W)
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [2:0]        pprot,
    output logic              pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    apb_state_e        state_q, state_d;
    logic              cmd_load;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout_hit;

    apb_master_cmd_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmd_reg (
        .clk_i   (pclk),
        .rst_i   (preset),
        .load_i  (cmd_load),
        .addr_i  (cmd_addr),
        .write_i (cmd_write),
        .wdata_i (cmd_wdata),
        .strb_i  (cmd_strb),
        .prot_i  (cmd_prot),
        .addr_o  (paddr),
        .write_o (pwrite),
        .wdata_o (pwdata),
        .strb_o  (pstrb),
        .prot_o  (pprot)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_q, wait_d;

    // Cleared during SETUP so the first ACCESS cycle sees zero.
    always_comb begin
        wait_d = wait_q;
        if (state_q == SETUP) begin
            wait_d = '0;
        end else if (state_q == ACCESS) begin
            wait_d = wait_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign timeout_hit = (state_q == ACCESS) && (wait_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        cmd_load  = 1'b0;
        pselx     = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_load = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                pselx   = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                pselx   = 1'b1;
                penable = 1'b1;
                // pready on the limit cycle completes normally.
                if (pready) begin
                    rdata_d = pwrite ? '0 : prdata;
                    err_d   = pslverr;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table-driven transfers with a response
// scoreboard, plus reset-abort, back-to-back and (APB_MASTER_TIMEOUT_EN) timeout sequences.
module tb_apb_master;
    import apb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          pselx, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pprot     (pprot),
        .pselx     (pselx),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int unsigned   waits;
        logic [DW-1:0] prdata;
        logic          pslverr;
        int unsigned   hold;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [SW-1:0] exp_pstrb;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge pclk);
    endtask

    // Control view: {pselx, penable, cmd_ready, rsp_valid}
    function automatic logic [3:0] ctl();
        return {pselx, penable, cmd_ready, rsp_valid};
    endfunction

    task automatic sb_check_rsp(input string name);
        rsp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: response seen with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            check({name, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            check({name, "_err"}, 64'(rsp_err), 64'(e.err));
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] s, input logic [2:0] p, input int unsigned wt,
                                input logic [DW-1:0] rd, input logic se, input int unsigned h,
                                input logic [DW-1:0] er, input logic ee, input logic [SW-1:0] es);
        vec_t v;
        v.write = w;  v.addr = a;   v.wdata = wd;   v.strb = s;      v.prot = p;
        v.waits = wt; v.prdata = rd; v.pslverr = se; v.hold = h;
        v.exp_rdata = er; v.exp_err = ee; v.exp_pstrb = es;
        return v;
    endfunction

    // One complete transfer from IDLE back to IDLE, acting as the APB slave.
    task automatic run_vec(input vec_t v, input string tag);
        check({tag, "_idle"}, 64'(ctl()), 64'(4'b0010));
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        cmd_prot  = v.prot;
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        pready    = 1'b1;
        prdata    = ~v.prdata;
        pslverr   = 1'b1;
        tick;
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        check({tag, "_setup_ctl"}, 64'({ctl(), pwrite, pprot, pstrb}),
              64'({4'b1000, v.write, v.prot, v.exp_pstrb}));
        check({tag, "_setup_bus"}, {paddr, pwdata}, {v.addr, v.wdata});
        for (int k = 0; k < 64; k++) begin
            tick;
            check({tag, "_access_ctl"}, 64'({ctl(), pwrite, pprot, pstrb}),
                  64'({4'b1100, v.write, v.prot, v.exp_pstrb}));
            check({tag, "_access_bus"}, {paddr, pwdata}, {v.addr, v.wdata});
            pready  = (k == int'(v.waits));
            prdata  = (k == int'(v.waits)) ? v.prdata : ~v.prdata;
            pslverr = (k == int'(v.waits)) ? v.pslverr : ~v.pslverr;
            if (k == int'(v.waits)) break;
        end
        tick;
        pready  = 1'b1;
        prdata  = 32'h0BAD_0BAD;
        pslverr = 1'b1;
        for (int h = 0; h < int'(v.hold); h++) begin
            check({tag, "_resp_hold_ctl"}, 64'(ctl()), 64'(4'b0001));
            check({tag, "_resp_hold_data"}, 64'({rsp_rdata, rsp_err}), 64'({v.exp_rdata, v.exp_err}));
            tick;
        end
        check({tag, "_resp_ctl"}, 64'(ctl()), 64'(4'b0001));
        rsp_ready = 1'b1;
        sb_check_rsp(tag);
        tick;
        rsp_ready = 1'b0;
        check({tag, "_back_idle"}, 64'(ctl()), 64'(4'b0010));
        check({tag, "_idle_hold_bus"}, {paddr, pwdata}, {v.addr, v.wdata});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t      vecs[5];
    logic [3:0] b2b_exp[9] = '{4'b0010, 4'b1000, 4'b1100, 4'b0001, 4'b0010,
                               4'b1000, 4'b1100, 4'b0001, 4'b0010};

    initial begin
        //          w     addr          wdata         strb  prot                     wt rdata         se   h  exp_rdata     ee   exp_pstrb
        vecs[0] = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, PROT_NORMAL,             0, 32'h5555_AAAA, 1'b0, 0, 32'h0,         1'b0, 4'hF);
        vecs[1] = mk(1'b0, 32'h0000_0020, 32'h1111_2222, 4'hF, PROT_PRIV,               3, 32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 4'h0);
        vecs[2] = mk(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h5, PROT_NONSEC,             1, 32'h7777_7777, 1'b1, 5, 32'h0,         1'b1, 4'h5);
        vecs[3] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, PROT_PRIV | PROT_NONSEC | PROT_INSTR,
                                                                                        2, 32'hCAFE_0000, 1'b1, 2, 32'hCAFE_0000, 1'b1, 4'h0);
        vecs[4] = mk(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h3, PROT_PRIV,               0, 32'h0,         1'b0, 1, 32'h0,         1'b0, 4'h3);

        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        repeat (3) @(posedge pclk);
        tick;
        check("reset_ctl", 64'(ctl()), 64'(4'b0010));
        check("reset_bus", {paddr, pwdata}, 64'h0);
        check("reset_misc", 64'({pprot, pwrite, pstrb, rsp_err, rsp_rdata}), 64'h0);
        preset = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while in ACCESS: transfer is dropped and never answered.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h44;
        cmd_prot  = PROT_PRIV;
        tick;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        tick;
        check("rst_mid_access", 64'(ctl()), 64'(4'b1100));
        preset = 1'b1;
        tick;
        check("rst_mid_ctl", 64'(ctl()), 64'(4'b0010));
        check("rst_mid_bus", {paddr, pwdata}, 64'h0);
        check("rst_mid_misc", 64'({pprot, pwrite, pstrb, rsp_err, rsp_rdata}), 64'h0);
        preset = 1'b0;
        pready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            check("rst_mid_no_rsp", 64'(ctl()), 64'(4'b0010));
        end

        // Back-to-back: command valid held across two transfers, response taken at once.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h100;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'hF;
        cmd_prot  = PROT_NORMAL;
        pready    = 1'b1;
        pslverr   = 1'b0;
        prdata    = 32'h600D_0001;
        rsp_ready = 1'b1;
        sb_q.push_back('{rdata: 32'h600D_0001, err: 1'b0});
        for (int c = 0; c < 9; c++) begin
            check($sformatf("b2b_ctl_c%0d", c), 64'(ctl()), 64'(b2b_exp[c]));
            if (c == 1) begin
                check("b2b_addr_a", 64'(paddr), 64'h100);
                cmd_write = 1'b1;
                cmd_addr  = 32'h104;
                cmd_wdata = 32'hB0B0_B0B0;
                sb_q.push_back('{rdata: 32'h0, err: 1'b0});
            end
            if (c == 3 || c == 7) sb_check_rsp($sformatf("b2b_rsp_c%0d", c));
            if (c == 5) begin
                check("b2b_bus_b", {paddr, pwdata}, {32'h104, 32'hB0B0_B0B0});
                cmd_valid = 1'b0;
            end
            tick;
        end
        rsp_ready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
        // pready never arrives: abort after TO ACCESS cycles.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h50;
        pready    = 1'b0;
        prdata    = 32'hFFFF_FFFF;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            tick;
            check($sformatf("to_access_c%0d", k), 64'(ctl()), 64'(4'b1100));
        end
        tick;
        check("to_resp_ctl", 64'(ctl()), 64'(4'b0001));
        rsp_ready = 1'b1;
        sb_check_rsp("to_rsp");
        tick;
        rsp_ready = 1'b0;
        check("to_back_idle", 64'(ctl()), 64'(4'b0010));
`else
        // Without the timeout, ACCESS waits as long as the slave stalls.
        run_vec(mk(1'b0, 32'h60, 32'h0, 4'hF, PROT_NONSEC, 20, 32'hA5A5_5A5A, 1'b0, 0,
                   32'hA5A5_5A5A, 1'b0, 4'h0), "long_wait");
`endif

        check("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
